// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared types and constants for the uart_tx requester arbiter
package uart_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_PAYLOAD = 2'd2
  } state_e;

  localparam logic [3:0] HEADER_TAG = 4'hA;

  // Width of the FIFO push / can_push count fields for a FIFO that accepts n bytes.
  function automatic int push_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin pick of one requester, searching upward from ptr_i with wrap
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [3:0]      ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [3:0]      idx_o
);

  logic [15:0] req_pad;
  logic [4:0]  sum;
  logic [3:0]  j;
  logic        found;

  assign req_pad = 16'(req_i);

  always_comb begin
    idx_o = '0;
    found = 1'b0;
    sum   = '0;
    j     = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, ptr_i} + 5'(i);
      j   = (sum >= 5'(NREQ)) ? 4'(sum - 5'(NREQ)) : sum[3:0];
      if (!found && req_pad[j]) begin
        found = 1'b1;
        idx_o = j;
      end
    end
  end

  always_comb begin
    gnt_o = '0;
    for (int k = 0; k < NREQ; k++) begin
      gnt_o[k] = found && (idx_o == 4'(k));
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packetises bytes from NREQ requesters into a uart_tx FIFO,
// prefixing each packet with a header byte {HEADER_TAG, owner} and aborting stalled owners.
module uart_tx_arbiter
  import uart_tx_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int N       = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*8-1:0]         req_data,
  input  logic [NREQ-1:0]           req_last,
  output logic [NREQ-1:0]           req_ready,
  output logic [push_width(N)-1:0]  push,
  input  logic [push_width(N)-1:0]  can_push,
  output logic [N*8-1:0]            data_o,
  output logic [3:0]                grant_id,
  output logic                      busy,
  output logic                      abort
);

  localparam int PW = push_width(N);
  localparam int DW = N * 8;
  localparam int CW = $clog2(TIMEOUT + 1);

  state_e          state_q;
  logic [3:0]      grant_q;
  logic [3:0]      rr_ptr_q;
  logic [CW-1:0]   tmo_q;
  logic            abort_q;

  logic [15:0]     valid_pad;
  logic [15:0]     last_pad;
  logic [127:0]    data_pad;
  logic [NREQ-1:0] arb_gnt;
  logic [3:0]      arb_idx;
  logic            can_ok;
  logic            g_valid;
  logic            g_last;
  logic [7:0]      g_byte;
  logic            accept;
  logic            idle_tick;
  logic            push_bit;
  logic [7:0]      lane0;
  logic [3:0]      next_ptr;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx)
  );

  // Padding to 16 requesters lets the 4-bit owner index select without width juggling.
  assign valid_pad = 16'(req_valid);
  assign last_pad  = 16'(req_last);
  assign data_pad  = 128'(req_data);

  assign can_ok    = (can_push != '0);
  assign g_valid   = valid_pad[grant_q];
  assign g_last    = last_pad[grant_q];
  assign g_byte    = data_pad[{grant_q, 3'b000} +: 8];
  assign accept    = (state_q == ST_PAYLOAD) && g_valid && can_ok;
  assign idle_tick = (state_q == ST_PAYLOAD) && !g_valid && can_ok;
  assign next_ptr  = (grant_q == 4'(NREQ - 1)) ? 4'd0 : grant_q + 4'd1;

  always_comb begin
    push_bit  = 1'b0;
    lane0     = 8'h00;
    req_ready = '0;
    case (state_q)
      ST_HEADER: begin
        push_bit = can_ok;
        lane0    = {HEADER_TAG, grant_q};
      end
      ST_PAYLOAD: begin
        push_bit = g_valid && can_ok;
        lane0    = g_byte;
        for (int k = 0; k < NREQ; k++) begin
          req_ready[k] = can_ok && (grant_q == 4'(k));
        end
      end
      default: ;
    endcase
  end

  assign push     = PW'(push_bit);
  assign data_o   = DW'(lane0);
  assign grant_id = grant_q;
  assign busy     = (state_q != ST_IDLE);
  assign abort    = abort_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      tmo_q    <= '0;
      abort_q  <= 1'b0;
    end else begin
      abort_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (|arb_gnt) begin
            grant_q <= arb_idx;
            state_q <= ST_HEADER;
          end
        end
        ST_HEADER: begin
          if (can_ok) begin
            state_q <= ST_PAYLOAD;
            tmo_q   <= '0;
          end
        end
        ST_PAYLOAD: begin
          if (accept) begin
            tmo_q <= '0;
            if (g_last) begin
              state_q  <= ST_IDLE;
              rr_ptr_q <= next_ptr;
              grant_q  <= '0;
            end
          end else if (idle_tick) begin
            // Only cycles where the FIFO could have taken a byte count toward the timeout.
            if (tmo_q == CW'(TIMEOUT - 1)) begin
              state_q  <= ST_IDLE;
              rr_ptr_q <= next_ptr;
              grant_q  <= '0;
              tmo_q    <= '0;
              abort_q  <= 1'b1;
            end else begin
              tmo_q <= tmo_q + CW'(1);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed vector bench for uart_tx_arbiter (NREQ=4, N=4, TIMEOUT=8)
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [2:0]  push;
  logic [2:0]  can_push;
  logic [31:0] data_o;
  logic [3:0]  grant_id;
  logic        busy;
  logic        abort;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NREQ(4), .N(4), .TIMEOUT(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .push      (push),
    .can_push  (can_push),
    .data_o    (data_o),
    .grant_id  (grant_id),
    .busy      (busy),
    .abort     (abort)
  );

  typedef struct {
    logic [3:0]  v;
    logic [31:0] d;
    logic [3:0]  l;
    logic [2:0]  cp;
    logic [2:0]  e_push;
    logic [7:0]  e_byte;
    logic [3:0]  e_ready;
    logic [3:0]  e_gid;
    logic        e_busy;
    logic        e_abort;
    logic        chk_data;
  } vec_t;

  vec_t single_tbl[$];
  vec_t rr_tbl[$];

  function automatic vec_t mk(input logic [3:0] v, input logic [31:0] d, input logic [3:0] l,
                              input logic [2:0] cp, input logic [2:0] ep, input logic [7:0] eb,
                              input logic [3:0] er, input logic [3:0] eg, input logic ebz,
                              input logic eab);
    vec_t x;
    x.v = v; x.d = d; x.l = l; x.cp = cp;
    x.e_push = ep; x.e_byte = eb; x.e_ready = er; x.e_gid = eg;
    x.e_busy = ebz; x.e_abort = eab; x.chk_data = 1'b1;
    return x;
  endfunction

  task automatic check(input string nm, input logic [44:0] act, input logic [44:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got {push,data,ready,gid,busy,abort}=%h want %h", nm, act, exp);
    end
  endtask

  // Called at a falling edge: drive, let combinational outputs settle, compare, advance one cycle.
  task automatic step(input vec_t x, input string nm);
    logic [31:0] dmask;
    req_valid = x.v;
    req_data  = x.d;
    req_last  = x.l;
    can_push  = x.cp;
    #1;
    dmask = x.chk_data ? 32'hFFFF_FFFF : 32'h0;
    check(nm, {push, data_o & dmask, req_ready, grant_id, busy, abort},
          {x.e_push, {24'h0, x.e_byte} & dmask, x.e_ready, x.e_gid, x.e_busy, x.e_abort});
    @(negedge clk);
  endtask

  task automatic do_reset(input string nm);
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    can_push  = 3'd4;
    #1;
    check(nm, {push, data_o, req_ready, grant_id, busy, abort}, 45'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    vec_t x;

    // req1 sends 0x55, 0x66(last): A1, 55, 66 on consecutive cycles.
    single_tbl.push_back(mk(4'b0010, 32'h0000_5500, 4'b0000, 3'd4, 3'd0, 8'h00, 4'b0000, 4'd0, 1'b0, 1'b0));
    single_tbl.push_back(mk(4'b0010, 32'h0000_5500, 4'b0000, 3'd4, 3'd1, 8'hA1, 4'b0000, 4'd1, 1'b1, 1'b0));
    single_tbl.push_back(mk(4'b0010, 32'h0000_5500, 4'b0000, 3'd4, 3'd1, 8'h55, 4'b0010, 4'd1, 1'b1, 1'b0));
    single_tbl.push_back(mk(4'b0010, 32'h0000_6600, 4'b0010, 3'd4, 3'd1, 8'h66, 4'b0010, 4'd1, 1'b1, 1'b0));
    single_tbl.push_back(mk(4'b0000, 32'h0000_0000, 4'b0000, 3'd4, 3'd0, 8'h00, 4'b0000, 4'd0, 1'b0, 1'b0));

    // req0/req2 contend after reset (req0 first), then req2/req3 contend (req3 wins).
    rr_tbl.push_back(mk(4'b0101, 32'h0022_0011, 4'b0101, 3'd4, 3'd0, 8'h00, 4'b0000, 4'd0, 1'b0, 1'b0));
    rr_tbl.push_back(mk(4'b0101, 32'h0022_0011, 4'b0101, 3'd1, 3'd1, 8'hA0, 4'b0000, 4'd0, 1'b1, 1'b0));
    rr_tbl.push_back(mk(4'b0101, 32'h0022_0011, 4'b0101, 3'd1, 3'd1, 8'h11, 4'b0001, 4'd0, 1'b1, 1'b0));
    rr_tbl.push_back(mk(4'b0101, 32'h0022_0011, 4'b0101, 3'd4, 3'd0, 8'h00, 4'b0000, 4'd0, 1'b0, 1'b0));
    rr_tbl.push_back(mk(4'b0101, 32'h0022_0011, 4'b0101, 3'd4, 3'd1, 8'hA2, 4'b0000, 4'd2, 1'b1, 1'b0));
    rr_tbl.push_back(mk(4'b0101, 32'h0022_0011, 4'b0101, 3'd2, 3'd1, 8'h22, 4'b0100, 4'd2, 1'b1, 1'b0));
    rr_tbl.push_back(mk(4'b1100, 32'h3322_0000, 4'b1100, 3'd4, 3'd0, 8'h00, 4'b0000, 4'd0, 1'b0, 1'b0));
    rr_tbl.push_back(mk(4'b1100, 32'h3322_0000, 4'b1100, 3'd4, 3'd1, 8'hA3, 4'b0000, 4'd3, 1'b1, 1'b0));
    rr_tbl.push_back(mk(4'b1100, 32'h3322_0000, 4'b1100, 3'd4, 3'd1, 8'h33, 4'b1000, 4'd3, 1'b1, 1'b0));
    rr_tbl.push_back(mk(4'b0000, 32'h0000_0000, 4'b0000, 3'd4, 3'd0, 8'h00, 4'b0000, 4'd0, 1'b0, 1'b0));

    do_reset("reset_state");
    foreach (single_tbl[i]) step(single_tbl[i], $sformatf("single[%0d]", i));

    do_reset("reset_state2");
    foreach (rr_tbl[i]) step(rr_tbl[i], $sformatf("rr[%0d]", i));

    // Backpressure: stall in HEADER, then 50 stalled PAYLOAD cycles with valid dropped.
    step(mk(4'b0010, 32'h0000_1000, 4'b0000, 3'd4, 3'd0, 8'h00, 4'b0000, 4'd0, 1'b0, 1'b0), "bp_idle");
    for (int i = 0; i < 3; i++) begin
      x = mk(4'b0010, 32'h0000_1000, 4'b0000, 3'd0, 3'd0, 8'h00, 4'b0000, 4'd1, 1'b1, 1'b0);
      x.chk_data = 1'b0;
      step(x, $sformatf("bp_hdr_stall[%0d]", i));
    end
    step(mk(4'b0010, 32'h0000_1000, 4'b0000, 3'd4, 3'd1, 8'hA1, 4'b0000, 4'd1, 1'b1, 1'b0), "bp_hdr");
    step(mk(4'b0010, 32'h0000_1000, 4'b0000, 3'd4, 3'd1, 8'h10, 4'b0010, 4'd1, 1'b1, 1'b0), "bp_byte0");
    for (int i = 0; i < 50; i++)
      step(mk(4'b0000, 32'h0000_2000, 4'b0010, 3'd0, 3'd0, 8'h20, 4'b0000, 4'd1, 1'b1, 1'b0),
           $sformatf("bp_stall[%0d]", i));
    step(mk(4'b0010, 32'h0000_2000, 4'b0010, 3'd4, 3'd1, 8'h20, 4'b0010, 4'd1, 1'b1, 1'b0), "bp_resume");
    step(mk(4'b0000, 32'h0000_0000, 4'b0000, 3'd4, 3'd0, 8'h00, 4'b0000, 4'd0, 1'b0, 1'b0), "bp_done");

    // Timeout: req0 goes silent after one byte; 8 idle cycles then abort, req1 served next.
    do_reset("reset_state3");
    step(mk(4'b0011, 32'h0000_8877, 4'b0010, 3'd4, 3'd0, 8'h00, 4'b0000, 4'd0, 1'b0, 1'b0), "to_idle");
    step(mk(4'b0011, 32'h0000_8877, 4'b0010, 3'd4, 3'd1, 8'hA0, 4'b0000, 4'd0, 1'b1, 1'b0), "to_hdr");
    step(mk(4'b0011, 32'h0000_8877, 4'b0010, 3'd4, 3'd1, 8'h77, 4'b0001, 4'd0, 1'b1, 1'b0), "to_byte0");
    for (int i = 0; i < 8; i++)
      step(mk(4'b0010, 32'h0000_8877, 4'b0010, 3'd4, 3'd0, 8'h77, 4'b0001, 4'd0, 1'b1, 1'b0),
           $sformatf("to_wait[%0d]", i));
    step(mk(4'b0010, 32'h0000_8877, 4'b0010, 3'd4, 3'd0, 8'h00, 4'b0000, 4'd0, 1'b0, 1'b1), "to_abort");
    step(mk(4'b0010, 32'h0000_8877, 4'b0010, 3'd4, 3'd1, 8'hA1, 4'b0000, 4'd1, 1'b1, 1'b0), "to_next_hdr");
    step(mk(4'b0010, 32'h0000_8877, 4'b0010, 3'd4, 3'd1, 8'h88, 4'b0010, 4'd1, 1'b1, 1'b0), "to_next_byte");
    step(mk(4'b0000, 32'h0000_0000, 4'b0000, 3'd4, 3'd0, 8'h00, 4'b0000, 4'd0, 1'b0, 1'b0), "to_done");

    // Reset mid-PAYLOAD with rr_ptr at 2: outputs clear at once, then req0 beats req2.
    step(mk(4'b0100, 32'h0099_0000, 4'b0000, 3'd4, 3'd0, 8'h00, 4'b0000, 4'd0, 1'b0, 1'b0), "rs_idle");
    step(mk(4'b0100, 32'h0099_0000, 4'b0000, 3'd4, 3'd1, 8'hA2, 4'b0000, 4'd2, 1'b1, 1'b0), "rs_hdr");
    step(mk(4'b0100, 32'h0099_0000, 4'b0000, 3'd4, 3'd1, 8'h99, 4'b0100, 4'd2, 1'b1, 1'b0), "rs_byte0");
    req_valid = 4'b0101;
    req_data  = 32'h0099_0011;
    req_last  = 4'b0001;
    can_push  = 3'd4;
    #2;
    rst = 1'b1;
    #1;
    check("rs_async", {push, data_o, req_ready, grant_id, busy, abort}, 45'h0);
    @(negedge clk);
    rst = 1'b0;
    step(mk(4'b0101, 32'h0099_0011, 4'b0001, 3'd4, 3'd0, 8'h00, 4'b0000, 4'd0, 1'b0, 1'b0), "rs_post_idle");
    step(mk(4'b0101, 32'h0099_0011, 4'b0001, 3'd4, 3'd1, 8'hA0, 4'b0000, 4'd0, 1'b1, 1'b0), "rs_post_hdr");
    step(mk(4'b0101, 32'h0099_0011, 4'b0001, 3'd4, 3'd1, 8'h11, 4'b0001, 4'd0, 1'b1, 1'b0), "rs_post_byte");
    step(mk(4'b0000, 32'h0000_0000, 4'b0000, 3'd4, 3'd0, 8'h00, 4'b0000, 4'd0, 1'b0, 1'b0), "rs_done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
